legv8_control_fsm: RTL and testbench

- Multi-cycle main control unit for the LEGv8 datapath (register file, ALU control, ALU, data memory, ALUSrc and MemtoReg muxes).
- It is the initiator/driver side of the datapath control interface:
  - takes the 11-bit instruction opcode field plus the ALU Zero flag;
  - sequences each instruction through fetch/decode/execute/memory/writeback;
  - drives ALUOp, MemRead, MemWrite, RegWrite, AluSrc, memtoReg, Reg2Loc and the PC/IR enables cycle by cycle.
- Also counts retired instructions and flags illegal opcodes.

---
 rtl/legv8_pkg.sv | 37 +++
 rtl/legv8_control_fsm_if.sv | 32 +++
 rtl/legv8_opclass_decode.sv | 23 ++
 rtl/legv8_control_fsm.sv | 151 +++++++++++++++
 tb/tb_legv8_control_fsm.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle control unit.
package legv8_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_ADDR = 4'd3,
        MEM_RD    = 4'd4,
        MEM_WR    = 4'd5,
        WB_R      = 4'd6,
        WB_LD     = 4'd7,
        BRANCH    = 4'd8,
        HALT      = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_LD  = 3'd1,
        CL_ST  = 3'd2,
        CL_CBZ = 3'd3,
        CL_ILL = 3'd4
    } opclass_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ_8 = 8'b10110100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/legv8_control_fsm_if.sv
// Control bundle between the LEGv8 control FSM (master) and the datapath.
interface legv8_control_fsm_if;
    import legv8_pkg::*;

    logic        instr_valid;
    logic        instr_ready;
    logic [10:0] OpCodefield;
    logic        Zero;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCWriteCond;
    logic [1:0]  ALUOp;
    logic        AluSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        memtoReg;
    logic        RegWrite;
    logic        Reg2Loc;

    modport master (
        input  instr_valid, OpCodefield, Zero,
        output instr_ready, IRWrite, PCWrite, PCWriteCond, ALUOp,
               AluSrc, MemRead, MemWrite, memtoReg, RegWrite, Reg2Loc
    );

    modport slave (
        output instr_valid, OpCodefield, Zero,
        input  instr_ready, IRWrite, PCWrite, PCWriteCond, ALUOp,
               AluSrc, MemRead, MemWrite, memtoReg, RegWrite, Reg2Loc
    );

endinterface

// File: rtl/legv8_opclass_decode.sv
// Maps the 11-bit LEGv8 opcode field onto an instruction class.
module legv8_opclass_decode
    import legv8_pkg::*;
(
    input  logic [10:0] op,
    output opclass_e    cls
);

    always_comb begin
        cls = CL_ILL;
        if (op[10:3] == OP_CBZ_8) begin
            cls = CL_CBZ;
        end else begin
            case (op)
                OP_ADD, OP_SUB, OP_AND, OP_ORR: cls = CL_R;
                OP_LDUR:                        cls = CL_LD;
                OP_STUR:                        cls = CL_ST;
                default:                        cls = CL_ILL;
            endcase
        end
    end

endmodule

// File: rtl/legv8_control_fsm.sv
// Multi-cycle LEGv8 main control: fetch/decode/execute/memory/writeback.
module legv8_control_fsm
    import legv8_pkg::*;
#(
    parameter int CNT_W           = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    legv8_control_fsm_if.master   dp,
    output logic                  done,
    output logic                  illegal,
    output logic [CNT_W-1:0]      retired,
    output logic [3:0]            state
);

    state_e           state_q, state_d;
    logic             is_st_q, is_st_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    opclass_e         cls;

    logic       instr_ready, ir_write, pc_write, pc_write_cond;
    logic [1:0] alu_op;
    logic       alu_src, mem_read, mem_write, mem_to_reg;
    logic       reg_write, reg2loc;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    legv8_opclass_decode u_dec (
        .op  (dp.OpCodefield),
        .cls (cls)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH;
            is_st_q   <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            is_st_q   <= is_st_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        is_st_d       = is_st_q;
        illegal_d     = illegal_q;
        retired_d     = retired_q;
        instr_ready   = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        alu_op        = ALUOP_ADD;
        alu_src       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg2loc       = 1'b0;
        done          = 1'b0;
        case (state_q)
            FETCH: begin
                instr_ready = 1'b1;
                if (dp.instr_valid) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            // Opcode is consumed only here; the LD/ST choice is kept in is_st_q.
            DECODE: begin
                reg2loc = (cls == CL_ST) || (cls == CL_CBZ);
                is_st_d = (cls == CL_ST);
                case (cls)
                    CL_R:          state_d = EXEC_R;
                    CL_LD, CL_ST:  state_d = EXEC_ADDR;
                    CL_CBZ:        state_d = BRANCH;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? HALT : FETCH;
                    end
                endcase
            end
            EXEC_R: begin
                alu_op  = ALUOP_RTYPE;
                state_d = WB_R;
            end
            WB_R: begin
                reg_write = 1'b1;
                done      = 1'b1;
                retired_d = retired_q + ONE;
                state_d   = FETCH;
            end
            EXEC_ADDR: begin
                alu_src = 1'b1;
                reg2loc = 1'b1;
                state_d = is_st_q ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                state_d  = WB_LD;
            end
            WB_LD: begin
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                done       = 1'b1;
                retired_d  = retired_q + ONE;
                state_d    = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                done      = 1'b1;
                retired_d = retired_q + ONE;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_op        = ALUOP_PASSB;
                reg2loc       = 1'b1;
                pc_write_cond = dp.Zero;
                done          = 1'b1;
                retired_d     = retired_q + ONE;
                state_d       = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign dp.instr_ready = instr_ready;
    assign dp.IRWrite     = ir_write;
    assign dp.PCWrite     = pc_write;
    assign dp.PCWriteCond = pc_write_cond;
    assign dp.ALUOp       = alu_op;
    assign dp.AluSrc      = alu_src;
    assign dp.MemRead     = mem_read;
    assign dp.MemWrite    = mem_write;
    assign dp.memtoReg    = mem_to_reg;
    assign dp.RegWrite    = reg_write;
    assign dp.Reg2Loc     = reg2loc;

    assign illegal = illegal_q;
    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Scoreboard bench for legv8_control_fsm: halting, resuming and 4-bit counter variants.
module tb_legv8_control_fsm;
    import legv8_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;
    legv8_control_fsm_if if0();
    legv8_control_fsm_if if1();
    legv8_control_fsm_if if2();

    logic        done0, ill0, done1, ill1, done2, ill2;
    logic [15:0] ret0, ret1;
    logic [3:0]  ret2;
    logic [3:0]  st0, st1, st2;

    legv8_control_fsm #(.CNT_W(16), .HALT_ON_ILLEGAL(1'b1)) dut0 (
        .clock(clk), .reset(rst0), .dp(if0), .done(done0),
        .illegal(ill0), .retired(ret0), .state(st0));
    legv8_control_fsm #(.CNT_W(16), .HALT_ON_ILLEGAL(1'b0)) dut1 (
        .clock(clk), .reset(rst1), .dp(if1), .done(done1),
        .illegal(ill1), .retired(ret1), .state(st1));
    legv8_control_fsm #(.CNT_W(4), .HALT_ON_ILLEGAL(1'b1)) dut2 (
        .clock(clk), .reset(rst2), .dp(if2), .done(done2),
        .illegal(ill2), .retired(ret2), .state(st2));

    int tests = 0;
    int fails = 0;
    bit mon_off = 1'b0;
    int ret_model = 0;

    typedef struct {
        int lat; int rd; int wr; int rw;
        int pcwc; int m2r; int aop; int src; int ret;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int lat, rd, wr, rw, pcwc, m2r, aop, src);
        exp_t e;
        e.lat = lat; e.rd = rd; e.wr = wr; e.rw = rw;
        e.pcwc = pcwc; e.m2r = m2r; e.aop = aop; e.src = src; e.ret = 0;
        return e;
    endfunction

    // Monitor: tracks one instruction on dut0 and scores it at its done pulse.
    initial begin
        int cyc = 0, nrd = 0, nwr = 0, nrw = 0, aop = 0, src = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst0) begin
                cyc = 0;
                continue;
            end
            chk("rd_wr_excl", 32'(if0.MemRead & if0.MemWrite), 0);
            chk("rw_wr_excl", 32'(if0.RegWrite & if0.MemWrite), 0);
            if (if0.instr_ready && if0.instr_valid) begin
                cyc = 1; nrd = 0; nwr = 0; nrw = 0; aop = 0; src = 0;
                chk("fetch_ir_pc", {if0.IRWrite, if0.PCWrite}, 2'b11);
            end else if (cyc > 0) begin
                cyc++;
            end
            if (cyc > 0) begin
                nrd += int'(if0.MemRead);
                nwr += int'(if0.MemWrite);
                nrw += int'(if0.RegWrite);
                if (cyc == 3) begin
                    aop = int'(if0.ALUOp);
                    src = int'(if0.AluSrc);
                end
            end
            if (done0 && !mon_off) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    e = q.pop_front();
                    chk("latency",   cyc, e.lat);
                    chk("memread_n", nrd, e.rd);
                    chk("memwr_n",   nwr, e.wr);
                    chk("regwr_n",   nrw, e.rw);
                    chk("pcwcond",   32'(if0.PCWriteCond), e.pcwc);
                    chk("memtoreg",  32'(if0.memtoReg), e.m2r);
                    chk("aluop_c3",  aop, e.aop);
                    chk("alusrc_c3", src, e.src);
                    chk("retired",   32'(ret0), e.ret);
                end
                cyc = 0;
            end
        end
    end

    task automatic issue(input logic [10:0] op, input logic z,
                         input bit push, input exp_t e);
        @(posedge clk); #1;
        if0.instr_valid = 1'b1;
        if0.OpCodefield = op;
        if0.Zero = z;
        if (push) begin
            e.ret = ret_model;
            q.push_back(e);
            ret_model = (ret_model + 1) & 16'hffff;
        end
        @(posedge clk); #1;
        if0.instr_valid = 1'b0;
        @(posedge clk); #1;
        if0.OpCodefield = ~op;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = done0;
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL done_timeout: got no done expected done");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t nul;
        nul = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst0 = 1; rst1 = 1; rst2 = 1;
        if0.instr_valid = 0; if0.OpCodefield = '0; if0.Zero = 0;
        if1.instr_valid = 0; if1.OpCodefield = '0; if1.Zero = 0;
        if2.instr_valid = 0; if2.OpCodefield = OP_ADD; if2.Zero = 0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 0; rst1 = 0; rst2 = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_state", st0, FETCH);
        chk("rst_ready", 32'(if0.instr_ready), 1);
        chk("rst_strobes", {if0.IRWrite, if0.PCWrite, if0.PCWriteCond,
            if0.ALUOp, if0.AluSrc, if0.MemRead, if0.MemWrite,
            if0.memtoReg, if0.RegWrite, if0.Reg2Loc, done0}, 0);
        chk("rst_retired", 32'(ret0), 0);
        chk("rst_illegal", 32'(ill0), 0);

        issue(OP_ADD, 0, 1, mk(4, 0, 0, 1, 0, 0, 2, 0)); wait_done();
        issue(OP_LDUR, 0, 1, mk(5, 2, 0, 1, 0, 1, 0, 1)); wait_done();
        issue(OP_STUR, 0, 1, mk(4, 0, 1, 0, 0, 0, 0, 1)); wait_done();
        issue(11'b10110100101, 1, 1, mk(3, 0, 0, 0, 1, 0, 1, 0)); wait_done();
        issue(11'b10110100101, 0, 1, mk(3, 0, 0, 0, 0, 0, 1, 0)); wait_done();
        issue(OP_SUB, 0, 1, mk(4, 0, 0, 1, 0, 0, 2, 0)); wait_done();
        issue(OP_ORR, 0, 1, mk(4, 0, 0, 1, 0, 0, 2, 0)); wait_done();
        @(negedge clk);
        chk("retired_7", 32'(ret0), 7);

        // Reset while the store is in its write cycle.
        mon_off = 1;
        issue(OP_STUR, 0, 0, nul);
        @(posedge clk); #1;
        chk("stur_in_memwr", 32'(if0.MemWrite), 1);
        rst0 = 1;
        @(posedge clk); #1;
        rst0 = 0;
        @(negedge clk);
        chk("post_rst_memwr", 32'(if0.MemWrite), 0);
        chk("post_rst_regwr", 32'(if0.RegWrite), 0);
        chk("post_rst_state", st0, FETCH);
        chk("post_rst_retired", 32'(ret0), 0);
        ret_model = 0;
        mon_off = 0;

        issue(OP_AND, 0, 1, mk(4, 0, 0, 1, 0, 0, 2, 0)); wait_done();
        issue(11'b00000000000, 0, 0, nul);
        if0.instr_valid = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("halt_state", st0, HALT);
        chk("halt_illegal", 32'(ill0), 1);
        chk("halt_retired", 32'(ret0), 1);
        chk("halt_ready", 32'(if0.instr_ready), 0);
        if0.instr_valid = 0;
        chk("queue_empty", q.size(), 0);

        // Non-halting variant resumes at FETCH.
        @(posedge clk); #1;
        if1.instr_valid = 1; if1.OpCodefield = 11'b0;
        @(posedge clk); #1;
        if1.instr_valid = 0;
        @(posedge clk); #1;
        chk("resume_state", st1, FETCH);
        chk("resume_illegal", 32'(ill1), 1);
        chk("resume_retired", 32'(ret1), 0);
        if1.instr_valid = 1; if1.OpCodefield = OP_ADD;
        @(posedge clk); #1;
        if1.instr_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("resume_add_ret", 32'(ret1), 1);
        chk("resume_ill_sticky", 32'(ill1), 1);

        // 17 back-to-back ADDs on the 4-bit counter.
        @(posedge clk); #1;
        if2.instr_valid = 1;
        repeat (65) @(posedge clk);
        #1;
        if2.instr_valid = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("wrap_retired", 32'(ret2), 1);
        chk("wrap_state", st2, FETCH);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
